// File: rtl/dac_pkg.sv
// Shared constants, FSM state encoding and channel/bit-slice map for the DAC sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only). State LDAC exists only with DAC_SYNC_LDAC_EN defined.
package dac_pkg;

    localparam int N_CH     = 14;
    localparam int FRAME_W  = 16;
    localparam int ADDR_W   = 4;
    localparam int VAL_W    = 8;
    localparam int N_WEIGHT = 10;
    localparam int N_DATA   = 4;
    localparam int SHADOW_W = N_CH * VAL_W;   // weights in the low bytes, data above them

    localparam logic [ADDR_W-1:0] LAST_CH = ADDR_W'(N_CH - 1);
    localparam logic [3:0]        LAST_BIT = 4'(FRAME_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
`ifdef DAC_SYNC_LDAC_EN
        ST_LDAC,
`endif
        ST_FIN
    } state_t;

    // Channel k occupies shadow bits [8k+7:8k]; channels 10..13 are the data bytes.
    function automatic logic [VAL_W-1:0] ch_value(input logic [SHADOW_W-1:0] shadow,
                                                  input logic [ADDR_W-1:0]   ch);
        return shadow[VAL_W*ch +: VAL_W];
    endfunction

    // One serial frame: {address, value, four zero pad bits}, sent MSB first.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [SHADOW_W-1:0] shadow,
                                                       input logic [ADDR_W-1:0]   ch);
        return {ch, ch_value(shadow, ch), 4'b0000};
    endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// SCLK rise/fall tick enables: one tick every CLK_DIV cycles, alternating rise then fall.
// Latency: first rise tick CLK_DIV cycles after clear drops; ticks are combinational from state.
// Backpressure: none; clear holds the divider at the start of a low half-period.
module sclk_tick_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic rise,
    output logic fall
);

    logic [7:0] div_cnt;
    logic       phase;      // 0: SCLK currently low, next tick is a rise
    logic       half_done;

    assign half_done = (div_cnt == 8'(CLK_DIV - 1));
    assign rise      = !clear && half_done && !phase;
    assign fall      = !clear && half_done &&  phase;

    // Half-period divider; clear restarts it so every frame begins with SCLK low.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            div_cnt <= 8'd0;
            phase   <= 1'b0;
        end else if (half_done) begin
            div_cnt <= 8'd0;
            phase   <= ~phase;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/dac_sequencer.sv
// Serialises 14 channel bytes into 16-bit DAC frames; optional LDAC strobe via DAC_SYNC_LDAC_EN.
// Latency: busy the cycle after accept; done 14*34*CLK_DIV+1 cycles after accept (+2*CLK_DIV with LDAC).
// Backpressure: start accepted only in IDLE; ignored (not queued) while busy or in the FIN cycle.
module dac_sequencer
    import dac_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [79:0] weights_in,
    input  logic [31:0] data_in,
    output logic        busy,
    output logic        done,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_mosi,
    output logic        dac_ldac_n
);

    state_t                state;
    state_t                state_nxt;
    logic [SHADOW_W-1:0]   shadow;
    logic [ADDR_W-1:0]     ch_cnt;
    logic [3:0]            bit_cnt;
    logic [8:0]            wait_cnt;
    logic                  sclk_q;
    logic                  accept;
    logic                  tick_clear;
    logic                  tick_rise;
    logic                  tick_fall;
    logic                  frame_end;
    logic                  wait_end;
    logic [FRAME_W-1:0]    frame_word;

    assign accept     = (state == ST_IDLE) && start;
    assign tick_clear = (state != ST_SHIFT);
    assign frame_end  = tick_fall && (bit_cnt == 4'd0);
    assign wait_end   = (wait_cnt == 9'(2 * CLK_DIV - 1));
    assign frame_word = build_frame(shadow, ch_cnt);

    sclk_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (tick_clear),
        .rise  (tick_rise),
        .fall  (tick_fall)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and bus outputs, decoded from the current state.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        dac_cs_n   = 1'b1;
        dac_sclk   = 1'b0;
        dac_mosi   = 1'b0;
`ifdef DAC_SYNC_LDAC_EN
        dac_ldac_n = 1'b1;
`else
        dac_ldac_n = 1'b0;   // DAC latches each frame on its own
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy     = 1'b1;
                dac_cs_n = 1'b0;
                dac_sclk = sclk_q;
                dac_mosi = frame_word[bit_cnt];
                if (frame_end) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                busy = 1'b1;
                if (wait_end) begin
                    if (ch_cnt != LAST_CH) begin
                        state_nxt = ST_SHIFT;
                    end else begin
`ifdef DAC_SYNC_LDAC_EN
                        state_nxt = ST_LDAC;
`else
                        state_nxt = ST_FIN;
`endif
                    end
                end
            end
`ifdef DAC_SYNC_LDAC_EN
            ST_LDAC: begin
                busy       = 1'b1;
                dac_ldac_n = 1'b0;
                if (wait_end) begin
                    state_nxt = ST_FIN;
                end
            end
`endif
            ST_FIN: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shadow capture and channel/bit counters; counters saturate at their final values.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            ch_cnt  <= '0;
            bit_cnt <= 4'd0;
        end else if (accept) begin
            shadow  <= {data_in, weights_in};
            ch_cnt  <= '0;
            bit_cnt <= LAST_BIT;
        end else if (state == ST_SHIFT) begin
            if (tick_fall && (bit_cnt != 4'd0)) begin
                bit_cnt <= bit_cnt - 4'd1;
            end
        end else if ((state == ST_GAP) && wait_end && (ch_cnt != LAST_CH)) begin
            ch_cnt  <= ch_cnt + 1'b1;
            bit_cnt <= LAST_BIT;
        end
    end

    // Cycle counter for the fixed-length GAP and LDAC states.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 9'd0;
        end else if ((state == ST_GAP)
`ifdef DAC_SYNC_LDAC_EN
                     || (state == ST_LDAC)
`endif
                    ) begin
            wait_cnt <= wait_end ? 9'd0 : wait_cnt + 9'd1;
        end else begin
            wait_cnt <= 9'd0;
        end
    end

    // SCLK level: rises and falls on the divider ticks, forced low outside SHIFT.
    always_ff @(posedge clk) begin
        if (rst || (state != ST_SHIFT)) begin
            sclk_q <= 1'b0;
        end else if (tick_rise) begin
            sclk_q <= 1'b1;
        end else if (tick_fall) begin
            sclk_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dac_sequencer.sv
// Bench for dac_sequencer: CLK_DIV=2 and CLK_DIV=1 instances, frames decoded from the serial bus.
// Latency: expected done cycle derived from frame/gap/ldac durations.
// Backpressure: restart and FIN-cycle start requests must be ignored.
module tb_dac_sequencer;

`ifdef DAC_SYNC_LDAC_EN
    localparam int LDAC_MULT = 2;
`else
    localparam int LDAC_MULT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [79:0] weights_in = '0;
    logic [31:0] data_in = '0;
    logic        sel_b = 1'b0;

    logic busy_a, done_a, cs_a, sclk_a, mosi_a, ldac_a;
    logic busy_b, done_b, cs_b, sclk_b, mosi_b, ldac_b;
    logic m_busy, m_done, m_cs_n, m_sclk, m_mosi, m_ldac_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dac_sequencer #(.CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .weights_in(weights_in), .data_in(data_in),
        .busy(busy_a), .done(done_a), .dac_cs_n(cs_a), .dac_sclk(sclk_a),
        .dac_mosi(mosi_a), .dac_ldac_n(ldac_a)
    );

    dac_sequencer #(.CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .weights_in(weights_in), .data_in(data_in),
        .busy(busy_b), .done(done_b), .dac_cs_n(cs_b), .dac_sclk(sclk_b),
        .dac_mosi(mosi_b), .dac_ldac_n(ldac_b)
    );

    assign m_busy   = sel_b ? busy_b : busy_a;
    assign m_done   = sel_b ? done_b : done_a;
    assign m_cs_n   = sel_b ? cs_b   : cs_a;
    assign m_sclk   = sel_b ? sclk_b : sclk_a;
    assign m_mosi   = sel_b ? mosi_b : mosi_a;
    assign m_ldac_n = sel_b ? ldac_b : ldac_a;

    task automatic set_start(input int cdiv, input logic v);
        if (cdiv == 1) start_b = v;
        else           start_a = v;
    endtask

    // Runs one update and checks timing and all 14 frames against the model.
    // mode 0: plain; 1: change weights at cycle 50 and re-pulse start at 100; 2: start in FIN cycle.
    task automatic do_transfer(input int cdiv, input logic [79:0] w, input logic [31:0] d,
                               input int mode, input string name,
                               output logic [15:0] f_first, output logic [15:0] f_last);
        int exp_done, exp_ldac_first, done_cnt, done_at, bad_busy, bad_cs, bad_gap, bad_rise;
        int bad_idle, bad_ldac, ldac_cnt, ldac_first, rises, low_run, high_run, last_rise, post_busy;
        int nf;
        logic prev_cs, prev_sc;
        logic [15:0] cur;
        logic [15:0] frames[$];
        logic [15:0] exp_f;
        logic [7:0]  b;

        sel_b          = (cdiv == 1);
        exp_ldac_first = 14 * 34 * cdiv + 1;
        exp_done       = 14 * 34 * cdiv + LDAC_MULT * cdiv + 1;
        done_cnt = 0; done_at = -1; bad_busy = 0; bad_cs = 0; bad_gap = 0; bad_rise = 0;
        bad_idle = 0; bad_ldac = 0; ldac_cnt = 0; ldac_first = -1; rises = 0; low_run = 0;
        high_run = 0; last_rise = -1; post_busy = 0; cur = '0;
        f_first = 'x; f_last = 'x;

        @(negedge clk);
        weights_in = w;
        data_in    = d;
        set_start(cdiv, 1'b1);
        prev_cs = 1'b1;
        prev_sc = 1'b0;

        for (int i = 1; i <= exp_done + 6; i++) begin
            @(negedge clk);
            if (m_done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (i < exp_done && m_busy !== 1'b1) bad_busy++;
            if (i >= exp_done && m_busy !== 1'b0) bad_busy++;
            if (mode == 2 && done_at >= 0 && (i == done_at + 1 || i == done_at + 2) && m_busy !== 1'b0)
                post_busy++;

            if (m_cs_n === 1'b0 && prev_cs === 1'b1) begin
                if (frames.size() > 0 && high_run != 2 * cdiv) bad_gap++;
                cur = '0; rises = 0; low_run = 0; last_rise = -1;
            end
            if (m_cs_n === 1'b1 && prev_cs === 1'b0) begin
                frames.push_back(cur);
                if (rises != 16) bad_rise++;
                if (low_run != 32 * cdiv) bad_cs++;
                high_run = 0;
            end
            if (m_cs_n === 1'b0) low_run++;
            else                 high_run++;
            if (m_cs_n === 1'b0 && m_sclk === 1'b1 && prev_sc === 1'b0) begin
                cur = {cur[14:0], m_mosi};
                rises++;
                if (last_rise < 0) begin
                    if (low_run != cdiv + 1) bad_rise++;
                end else if (i - last_rise != 2 * cdiv) begin
                    bad_rise++;
                end
                last_rise = i;
            end
            if (m_cs_n === 1'b1 && (m_sclk !== 1'b0 || m_mosi !== 1'b0)) bad_idle++;

`ifdef DAC_SYNC_LDAC_EN
            if (m_ldac_n === 1'b0) begin
                ldac_cnt++;
                if (ldac_first < 0) ldac_first = i;
            end else if (m_ldac_n !== 1'b1) begin
                bad_ldac++;
            end
`else
            if (m_ldac_n !== 1'b0) bad_ldac++;
`endif

            if (i == 1) set_start(cdiv, 1'b0);
            if (mode == 1 && i == 50)  weights_in = {16'($urandom), $urandom, $urandom};
            if (mode == 1 && i == 100) set_start(cdiv, 1'b1);
            if (mode == 1 && i == 101) set_start(cdiv, 1'b0);
            if (mode == 2 && i == done_at) set_start(cdiv, 1'b1);
            if (mode == 2 && done_at >= 0 && i == done_at + 1) set_start(cdiv, 1'b0);
            prev_cs = m_cs_n;
            prev_sc = m_sclk;
        end
        set_start(cdiv, 1'b0);

        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
        end
        checks++;
        if (done_at !== exp_done) begin
            errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_at, exp_done);
        end
        checks++;
        if (bad_busy !== 0) begin
            errors++; $display("FAIL %s busy_window: %0d bad cycles want 0", name, bad_busy);
        end
        checks++;
        if (frames.size() !== 14) begin
            errors++; $display("FAIL %s frame_count: got %0d want 14", name, frames.size());
        end
        nf = (frames.size() < 14) ? frames.size() : 14;
        for (int k = 0; k < nf; k++) begin
            b = (k < 10) ? 8'(w >> (8 * k)) : 8'(d >> (8 * (k - 10)));
            exp_f = {4'(k), b, 4'h0};
            checks++;
            if (frames[k] !== exp_f) begin
                errors++; $display("FAIL %s frame[%0d]: got %h want %h", name, k, frames[k], exp_f);
            end
        end
        if (nf > 0) begin
            f_first = frames[0];
            f_last  = frames[nf-1];
        end
        checks++;
        if (bad_cs !== 0) begin
            errors++; $display("FAIL %s cs_low_len: %0d frames not %0d cycles", name, bad_cs, 32 * cdiv);
        end
        checks++;
        if (bad_gap !== 0) begin
            errors++; $display("FAIL %s gap_len: %0d gaps not %0d cycles", name, bad_gap, 2 * cdiv);
        end
        checks++;
        if (bad_rise !== 0) begin
            errors++; $display("FAIL %s sclk_timing: %0d violations want 0", name, bad_rise);
        end
        checks++;
        if (bad_idle !== 0) begin
            errors++; $display("FAIL %s idle_bus: %0d cycles with sclk/mosi high while cs_n high", name, bad_idle);
        end
        checks++;
        if (bad_ldac !== 0) begin
            errors++; $display("FAIL %s ldac_level: %0d bad cycles want 0", name, bad_ldac);
        end
`ifdef DAC_SYNC_LDAC_EN
        checks++;
        if (ldac_cnt !== 2 * cdiv || ldac_first !== exp_ldac_first) begin
            errors++;
            $display("FAIL %s ldac_pulse: low %0d cycles from %0d want %0d from %0d",
                     name, ldac_cnt, ldac_first, 2 * cdiv, exp_ldac_first);
        end
`endif
        if (mode == 2) begin
            checks++;
            if (post_busy !== 0) begin
                errors++; $display("FAIL %s fin_start_accepted: busy in %0d cycles after FIN want 0", name, post_busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cs_a, sclk_a, mosi_a, busy_a, done_a} !== 5'b10000) begin
            errors++; $display("FAIL reset_bus_a: got %b want 10000", {cs_a, sclk_a, mosi_a, busy_a, done_a});
        end
        checks++;
        if ({cs_b, sclk_b, mosi_b, busy_b, done_b} !== 5'b10000) begin
            errors++; $display("FAIL reset_bus_b: got %b want 10000", {cs_b, sclk_b, mosi_b, busy_b, done_b});
        end
        checks++;
        if (ldac_a !== (LDAC_MULT != 0)) begin
            errors++; $display("FAIL reset_ldac: got %b want %b", ldac_a, (LDAC_MULT != 0));
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_update();
        logic [15:0] f0, f13;
        do_transfer(2, 80'h0, 32'h0, 0, "zero", f0, f13);
    endtask

    task automatic test_frame_format();
        logic [15:0] f0, f13;
        logic [79:0] w;
        logic [31:0] d;
        w = {16'($urandom), $urandom, $urandom};
        d = $urandom;
        w[7:0]   = 8'hA5;
        d[31:24] = 8'h3C;
        do_transfer(2, w, d, 0, "format", f0, f13);
        checks++;
        if (f0 !== 16'h0A50) begin
            errors++; $display("FAIL format_ch0: got %h want 0a50", f0);
        end
        checks++;
        if (f13 !== 16'hD3C0) begin
            errors++; $display("FAIL format_ch13: got %h want d3c0", f13);
        end
    endtask

    task automatic test_random();
        logic [15:0] f0, f13;
        for (int n = 0; n < 3; n++) begin
            do_transfer(2, {16'($urandom), $urandom, $urandom}, $urandom, 0, "random", f0, f13);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] f0, f13;
        do_transfer(2, {16'($urandom), $urandom, $urandom}, $urandom, 1, "restart_ignored", f0, f13);
        do_transfer(2, {16'($urandom), $urandom, $urandom}, $urandom, 2, "fin_start", f0, f13);
    endtask

    task automatic test_reset_mid();
        int mid, done_cnt, bad_busy;
        logic [15:0] f0, f13;
        sel_b    = 1'b0;
        mid      = 1 + 5 * 68 + 20;
        done_cnt = 0;
        bad_busy = 0;
        @(negedge clk);
        weights_in = {16'($urandom), $urandom, $urandom};
        data_in    = $urandom;
        start_a    = 1'b1;
        for (int i = 1; i <= mid; i++) begin
            @(negedge clk);
            if (m_done === 1'b1) done_cnt++;
            if (i == 1) start_a = 1'b0;
        end
        checks++;
        if (m_cs_n !== 1'b0 || m_busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_precond: cs_n=%b busy=%b want 0 1", m_cs_n, m_busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_cs_n, m_sclk, m_mosi, m_busy, m_done} !== 5'b10000) begin
            errors++; $display("FAIL rst_mid_bus: got %b want 10000", {m_cs_n, m_sclk, m_mosi, m_busy, m_done});
        end
        rst = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (m_done === 1'b1) done_cnt++;
            if (m_busy !== 1'b0) bad_busy++;
        end
        checks++;
        if (done_cnt !== 0 || bad_busy !== 0) begin
            errors++; $display("FAIL rst_mid_no_done: done=%0d busy_cycles=%0d want 0 0", done_cnt, bad_busy);
        end
        do_transfer(2, {16'($urandom), $urandom, $urandom}, $urandom, 0, "after_rst", f0, f13);
        checks++;
        if (f0[15:12] !== 4'd0) begin
            errors++; $display("FAIL after_rst_first_ch: got %0d want 0", f0[15:12]);
        end
    endtask

    task automatic test_clk_div1();
        logic [15:0] f0, f13;
        do_transfer(1, {16'($urandom), $urandom, $urandom}, $urandom, 0, "div1", f0, f13);
        do_transfer(1, 80'h0, 32'hFFFF_FFFF, 0, "div1_data", f0, f13);
        sel_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_update();
        test_frame_format();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_clk_div1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dac_sequencer.md
DAC_SEQUENCER -- requirements
Module: dac_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have port clk  input  1  the single system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to transmit one full update.
REQ-005 SHALL have port weights_in  input  80  ten 8-bit weights; channel k is bits [8k+7:8k].
REQ-006 SHALL have port data_in  input  32  four 8-bit data values; channel 10+k is bits [8k+7:8k].
REQ-007 SHALL have port busy  output  1  high from accept until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse at the end of an update.
REQ-009 SHALL have ports dac_cs_n, dac_sclk, dac_mosi and dac_ldac_n, each an output of width 1, forming the DAC serial bus.

Function
REQ-010 SHALL accept start only in IDLE; on accept, weights_in and data_in are latched into a 112-bit shadow register, and busy rises the next cycle.
REQ-011 SHALL ignore start while busy, with no queuing and no restart.
REQ-012 SHALL transmit channels 0..13 in ascending order, one 16-bit frame each: {addr[3:0]=channel, value[7:0], 4'b0000}, MSB first.
REQ-013 SHALL use FSM states IDLE -> SHIFT -> GAP -> (SHIFT for the next channel | LDAC | FIN) -> IDLE.
REQ-014 SHALL drive dac_cs_n low from the cycle after accept, for 32*CLK_DIV cycles per frame (SHIFT).
REQ-015 SHALL keep dac_sclk low at the start of a frame and toggle it every CLK_DIV cycles; dac_mosi changes only on SCLK falling transitions (or frame start), so it is stable at every rising edge; the frame contains 16 rising edges.
REQ-016 SHALL hold dac_cs_n high, dac_sclk low and dac_mosi 0 for 2*CLK_DIV cycles after each frame (GAP).
REQ-017 SHALL, after the 14th GAP, enter LDAC (macro defined) or FIN (macro undefined); FIN pulses done for one cycle, deasserts busy in the same cycle, and returns to IDLE.
REQ-018 SHALL, when start is presented in the FIN cycle, not accept it (accept occurs only in IDLE, one cycle later).
REQ-019 SHALL not alter a transmission in progress when weights_in or data_in change.
REQ-020 SHALL keep a 4-bit channel counter (0..13) and a 4-bit bit counter (15..0) that stop at their final values and do not wrap.

Reset
REQ-021 SHALL, on rst at any time including mid-frame, enter IDLE next cycle with dac_cs_n=1, dac_sclk=0, dac_mosi=0, dac_ldac_n=1 (macro defined) or 0 (undefined), busy=0, done=0, and counters and shadow cleared.
REQ-022 SHALL not assert done for an update aborted by reset.

Configuration
REQ-023 SHALL use macro DAC_SYNC_LDAC_EN; when it is defined, dac_ldac_n idles high and is driven low for 2*CLK_DIV cycles in state LDAC after the last GAP, then FIN follows.
REQ-024 SHALL, when DAC_SYNC_LDAC_EN is undefined, tie dac_ldac_n to 0 (the DAC updates per frame), omit state LDAC, and go GAP -> FIN directly.

Structure
REQ-025 SHALL take N_CH=14, FRAME_W=16, ADDR_W=4, the state enumeration and the channel/bit-slice map from shared package dac_pkg.
REQ-026 SHALL instantiate one sub-module, sclk_tick_gen, producing rise/fall tick enables from CLK_DIV with a synchronous clear at frame start.

Verification
REQ-027 SHALL verify: CLK_DIV=2, macro undefined, start with weights_in=80'h0, data_in=32'h0 -> done pulses exactly 953 cycles after the accept cycle; busy high throughout.
REQ-028 SHALL verify: weights_in[7:0]=8'hA5, channel 0 frame -> MOSI sampled on 16 SCLK rises = 16'h0A50; channel 13 frame with data_in[31:24]=8'h3C -> 16'hD3C0.
REQ-029 SHALL verify: CLK_DIV=2, macro defined -> dac_ldac_n low for exactly 4 cycles starting after the 14th GAP; done arrives at cycle 957.
REQ-030 SHALL verify: start pulsed again at cycle 100 of a transfer and weights_in changed at cycle 50 -> single done only; transmitted values equal those latched at accept.
REQ-031 SHALL verify: rst asserted mid-frame of channel 5 -> next cycle dac_cs_n=1, busy=0, no done; a subsequent start transmits from channel 0.
REQ-032 SHALL verify: CLK_DIV=1 -> SCLK period is 2 clk cycles, frame spans 32 cycles of dac_cs_n low, and the GAP lasts 2 cycles.
